// File: rtl/ysyx_22040127_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040127_div_iter
// Description : Iterative radix-2 restoring divider. It produces one quotient
//               bit per cycle and handles signed and unsigned operands.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040127_div_iter #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            div_valid,
    input  logic            div_signed,
    input  logic            div_flush,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            div_ready,
    output logic [1:0]      div_state,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PREP = 2'b01,
        S_CALC = 2'b10,
        S_DONE = 2'b11
    } state_t;

    localparam logic [XLEN-1:0] c_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            r_state;
    state_t            w_next;
    logic              r_ready;
    logic [XLEN-1:0]   r_dividend;
    logic [XLEN-1:0]   r_divisor;
    logic              r_signed;
    logic [XLEN-1:0]   r_dvs_abs;
    logic              r_q_neg;
    logic              r_r_neg;
    // The partial remainder is always below |divisor|, so XLEN bits hold it;
    // the extra trial bit only lives in the subtraction result.
    logic [XLEN-1:0]   r_pr;
    logic [XLEN-1:0]   r_q;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_quotient;
    logic [XLEN-1:0]   r_remainder;

    logic              w_sign1;
    logic              w_sign2;
    logic [XLEN-1:0]   w_dvd_abs;
    logic [XLEN-1:0]   w_dvs_abs;
    logic              w_div_zero;
    logic              w_overflow;
    logic              w_special;
    logic [XLEN:0]     w_trial;
    logic [XLEN-1:0]   w_pr_next;
    logic [XLEN-1:0]   w_q_next;
    logic [XLEN-1:0]   w_q_final;
    logic [XLEN-1:0]   w_r_final;

    assign w_sign1    = r_signed & r_dividend[XLEN-1];
    assign w_sign2    = r_signed & r_divisor[XLEN-1];
    assign w_dvd_abs  = w_sign1 ? (-r_dividend) : r_dividend;
    assign w_dvs_abs  = w_sign2 ? (-r_divisor) : r_divisor;
    assign w_div_zero = (r_divisor == '0);
    assign w_overflow = r_signed && (r_dividend == c_INT_MIN) && (r_divisor == '1);
    assign w_special  = w_div_zero | w_overflow;

    assign w_trial   = {r_pr, r_q[XLEN-1]} - {1'b0, r_dvs_abs};
    assign w_pr_next = w_trial[XLEN] ? {r_pr[XLEN-2:0], r_q[XLEN-1]} : w_trial[XLEN-1:0];
    assign w_q_next  = {r_q[XLEN-2:0], ~w_trial[XLEN]};
    assign w_q_final = r_q_neg ? (-w_q_next) : w_q_next;
    assign w_r_final = r_r_neg ? (-w_pr_next) : w_pr_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == S_DONE);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (div_valid && !div_flush) w_next = S_PREP;
            S_PREP: begin
                if (div_flush)      w_next = S_IDLE;
                else if (w_special) w_next = S_DONE;
                else                w_next = S_CALC;
            end
            S_CALC: begin
                if (div_flush)           w_next = S_IDLE;
                else if (r_cnt == '0)    w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_signed    <= 1'b0;
            r_dvs_abs   <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_pr        <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (div_valid && !div_flush) begin
                        r_dividend <= dividend;
                        r_divisor  <= divisor;
                        r_signed   <= div_signed;
                    end
                end
                S_PREP: begin
                    if (!div_flush) begin
                        r_q_neg   <= w_sign1 ^ w_sign2;
                        r_r_neg   <= w_sign1;
                        r_dvs_abs <= w_dvs_abs;
                        if (w_div_zero) begin
                            r_quotient  <= '1;
                            r_remainder <= r_dividend;
                        end else if (w_overflow) begin
                            r_quotient  <= r_dividend;
                            r_remainder <= '0;
                        end else begin
                            r_pr  <= '0;
                            r_q   <= w_dvd_abs;
                            r_cnt <= CNT_W'(XLEN - 1);
                        end
                    end
                end
                S_CALC: begin
                    if (!div_flush) begin
                        r_pr <= w_pr_next;
                        r_q  <= w_q_next;
                        if (r_cnt == '0) begin
                            r_quotient  <= w_q_final;
                            r_remainder <= w_r_final;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_ready = r_ready;
    assign div_state = r_state;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040127_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22040127_div_iter
// Description : Scoreboard bench for the iterative divider, directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040127_div_iter;

    logic        clk;
    logic        rst;
    logic        div_valid;
    logic        div_signed;
    logic        div_flush;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        div_ready;
    logic [1:0]  div_state;
    logic [63:0] quotient;
    logic [63:0] remainder;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    ysyx_22040127_div_iter #(.XLEN(64), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_valid  (div_valid),
        .div_signed (div_signed),
        .div_flush  (div_flush),
        .dividend   (dividend),
        .divisor    (divisor),
        .div_ready  (div_ready),
        .div_state  (div_state),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && div_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("quotient", quotient, mon_e.q);
                chk("remainder", remainder, mon_e.r);
                chk("ready_cycle", 64'(cyc), 64'(mon_e.due));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic advance_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sb.size() != 0 || div_state != 2'b00) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending expected 0 (cycle %0d)", sb.size(), cyc);
            sb.delete();
        end
    endtask

    task automatic start(input logic [63:0] a, input logic [63:0] b, input logic s);
        dividend   = a;
        divisor    = b;
        div_signed = s;
        div_valid  = 1'b1;
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic s,
                         input logic [63:0] eq, input logic [63:0] er, input int lat);
        start(a, b, s);
        sb.push_back('{q: eq, r: er, due: cyc + lat});
        tick();
        div_valid = 1'b0;
        wait_done();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin : stim
        int c0;
        rst        = 1'b1;
        div_valid  = 1'b0;
        div_signed = 1'b0;
        div_flush  = 1'b0;
        dividend   = '0;
        divisor    = '0;
        repeat (3) tick();
        chk("rst_state", 64'(div_state), 64'd0);
        chk("rst_ready", 64'(div_ready), 64'd0);
        chk("rst_quotient", quotient, 64'd0);
        chk("rst_remainder", remainder, 64'd0);
        rst = 1'b0;
        tick();

        // 100 / 7 unsigned with state timeline
        c0 = cyc;
        start(64'd100, 64'd7, 1'b0);
        sb.push_back('{q: 64'd14, r: 64'd2, due: c0 + 66});
        tick();
        div_valid = 1'b0;
        chk("state_prep", 64'(div_state), 64'd1);
        advance_to(c0 + 2);
        chk("state_calc_first", 64'(div_state), 64'd2);
        advance_to(c0 + 30);
        chk("quotient_hold_calc", quotient, 64'd0);
        advance_to(c0 + 65);
        chk("state_calc_last", 64'(div_state), 64'd2);
        advance_to(c0 + 66);
        chk("state_done", 64'(div_state), 64'd3);
        chk("ready_done", 64'(div_ready), 64'd1);
        advance_to(c0 + 67);
        chk("state_idle_after", 64'(div_state), 64'd0);
        chk("ready_low_after", 64'(div_ready), 64'd0);
        wait_done();
        chk("quotient_hold_idle", quotient, 64'd14);

        // Signed vectors
        issue(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        issue(64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 66);
        issue(64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 66);

        // Divide by zero
        issue(64'h1234, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 2);
        issue(64'h1234, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 2);
        issue(64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 2);

        // Signed overflow, then same operands unsigned
        issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h8000_0000_0000_0000, 64'd0, 2);
        issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 64'h8000_0000_0000_0000, 66);

        // Flush mid-operation, then 5 / 5
        tick();
        c0 = cyc;
        start(64'd100, 64'd7, 1'b0);
        tick();
        div_valid = 1'b0;
        advance_to(c0 + 10);
        div_flush = 1'b1;
        tick();
        div_flush = 1'b0;
        chk("flush_state", 64'(div_state), 64'd0);
        chk("flush_quotient_kept", quotient, 64'h8000_0000_0000_0000 - 64'h8000_0000_0000_0000);
        chk("flush_remainder_kept", remainder, 64'h8000_0000_0000_0000);
        repeat (3) tick();
        issue(64'd5, 64'd5, 1'b0, 64'd1, 64'd0, 66);

        // Reset mid-CALC
        c0 = cyc;
        start(64'd100, 64'd7, 1'b0);
        tick();
        div_valid = 1'b0;
        advance_to(c0 + 20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_state", 64'(div_state), 64'd0);
        chk("midrst_ready", 64'(div_ready), 64'd0);
        chk("midrst_quotient", quotient, 64'd0);
        chk("midrst_remainder", remainder, 64'd0);
        tick();

        // Request held through DONE; operand changes during CALC are ignored
        c0 = cyc;
        start(64'd100, 64'd7, 1'b0);
        sb.push_back('{q: 64'd14, r: 64'd2, due: c0 + 66});
        sb.push_back('{q: 64'd1, r: 64'd0, due: c0 + 133});
        advance_to(c0 + 10);
        dividend = 64'd5;
        divisor  = 64'd5;
        advance_to(c0 + 67);
        chk("b2b_idle", 64'(div_state), 64'd0);
        tick();
        div_valid = 1'b0;
        chk("b2b_prep", 64'(div_state), 64'd1);
        wait_done();

        repeat (3) tick();
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
